// File: rtl/alu_multicycle_seq.sv
// Multi-cycle execute-stage sequencer: iterative shift-add MULT and weighted
// RGB-to-gray AV. Stalls the pipeline while busy and presents a one-cycle registered result.
module alu_multicycle_seq #(
  parameter int unsigned W_R     = 77,
  parameter int unsigned W_G     = 150,
  parameter int unsigned W_B     = 29,
  parameter logic [3:0]  OP_MULT = 4'd3,
  parameter logic [3:0]  OP_AV   = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StartE,
  input  logic [3:0]  ALUControlE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        KillE,
  output logic        StallMC,
  output logic [31:0] ResultMC,
  output logic        DoneMC,
  output logic        ZeroMC
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_AVG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Weights sum to 256, so each fits in 9 bits.
  localparam logic [8:0] LP_W_R = 9'(W_R);
  localparam logic [8:0] LP_W_G = 9'(W_G);
  localparam logic [8:0] LP_W_B = 9'(W_B);

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [23:0] r_pix;
  logic [1:0]  r_ch;
  logic [31:0] r_result;
  logic        r_done;
  logic        r_zero;

  logic        w_mc_op;
  logic        w_start;
  logic [31:0] w_mul_acc_next;
  logic [31:0] w_mplier_next;
  logic        w_mul_last;
  logic [17:0] w_av_acc_next;
  logic        w_av_last;

  function automatic logic [17:0] f_av_term(input logic [23:0] pix, input logic [1:0] ch);
    logic [7:0] chan;
    logic [8:0] wt;
    case (ch)
      2'd0: begin
        chan = pix[23:16];
        wt   = LP_W_R;
      end
      2'd1: begin
        chan = pix[15:8];
        wt   = LP_W_G;
      end
      2'd2: begin
        chan = pix[7:0];
        wt   = LP_W_B;
      end
      default: begin
        chan = 8'd0;
        wt   = 9'd0;
      end
    endcase
    return 18'(chan) * 18'(wt);
  endfunction

  assign w_mc_op = StartE && ((ALUControlE == OP_MULT) || (ALUControlE == OP_AV));
  assign w_start = (r_state == S_IDLE) && w_mc_op && !KillE;
  assign StallMC = w_start || (r_state == S_MUL) || (r_state == S_AVG);

  assign ResultMC = r_result;
  assign DoneMC   = r_done;
  assign ZeroMC   = r_zero;

  // Next-value datapath for one shift-add step and one weighted-channel step.
  always_comb begin
    w_mul_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_next  = {1'b0, r_mplier[31:1]};
    w_mul_last     = (w_mplier_next == 32'd0) || (r_cnt == 5'd31);
    w_av_acc_next  = r_acc[17:0] + f_av_term(r_pix, r_ch);
    w_av_last      = (r_ch == 2'd2);
  end

  // Sequencer FSM with registered result, done and zero flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_acc    <= 32'd0;
      r_cnt    <= 5'd0;
      r_pix    <= 24'd0;
      r_ch     <= 2'd0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_acc <= 32'd0;
            r_cnt <= 5'd0;
            r_ch  <= 2'd0;
            if (ALUControlE == OP_MULT) begin
              r_mcand  <= SrcAE;
              r_mplier <= SrcBE;
              r_state  <= S_MUL;
            end else begin
              r_pix   <= SrcAE[23:0];
              r_state <= S_AVG;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          if (KillE) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_mul_acc_next;
            r_mcand  <= {r_mcand[30:0], 1'b0};
            r_mplier <= w_mplier_next;
            r_cnt    <= r_cnt + 5'd1;
            if (w_mul_last) begin
              r_result <= w_mul_acc_next;
              r_zero   <= (w_mul_acc_next == 32'd0);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_MUL;
            end
          end
        end
        S_AVG: begin
          if (KillE) begin
            r_state <= S_IDLE;
          end else begin
            // Gray value is acc/256; the weight sum guarantees it stays within 8 bits.
            r_acc <= {14'd0, w_av_acc_next};
            r_ch  <= r_ch + 2'd1;
            if (w_av_last) begin
              r_result <= {24'd0, w_av_acc_next[15:8]};
              r_zero   <= (w_av_acc_next[15:8] == 8'd0);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_AVG;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle_seq.sv
// Self-checking bench for alu_multicycle_seq: latency/result model plus directed literal checks.
module tb_alu_multicycle_seq;

  localparam logic [3:0] OP_MULT = 4'd3;
  localparam logic [3:0] OP_AV   = 4'd4;
  localparam int unsigned WR = 77;
  localparam int unsigned WG = 150;
  localparam int unsigned WB = 29;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StartE;
  logic [3:0]  ALUControlE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        KillE;
  logic        StallMC;
  logic [31:0] ResultMC;
  logic        DoneMC;
  logic        ZeroMC;

  int n_tests = 0;
  int n_fail  = 0;

  alu_multicycle_seq #(
    .W_R(WR), .W_G(WG), .W_B(WB), .OP_MULT(OP_MULT), .OP_AV(OP_AV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .StartE(StartE), .ALUControlE(ALUControlE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .KillE(KillE), .StallMC(StallMC),
    .ResultMC(ResultMC), .DoneMC(DoneMC), .ZeroMC(ZeroMC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned k_of(input logic [31:0] b);
    int unsigned k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  function automatic logic [31:0] gray(input logic [31:0] p);
    int unsigned s;
    s = int'(p[23:16]) * WR + int'(p[15:8]) * WG + int'(p[7:0]) * WB;
    return 32'(s / 256);
  endfunction

  // Behavioural model: on an accepted start, remember the answer and how many busy cycles remain.
  int unsigned m_rem;
  logic        m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;
  logic        m_zero;
  logic        mc_req;

  assign mc_req = StartE && ((ALUControlE == OP_MULT) || (ALUControlE == OP_AV));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= 32'd0;
      m_pend <= 32'd0;
      m_zero <= 1'b1;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_rem != 0) begin
      if (KillE) begin
        m_rem <= 0;
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
          m_zero <= (m_pend == 32'd0);
        end
      end
    end else if (mc_req && !KillE) begin
      if (ALUControlE == OP_MULT) begin
        m_rem  <= k_of(SrcBE);
        m_pend <= SrcAE * SrcBE;
      end else begin
        m_rem  <= 3;
        m_pend <= gray(SrcAE);
      end
    end
  end

  always @(negedge clk) begin
    chk("stall",  32'(StallMC),  32'((m_rem != 0) || (!m_done && mc_req && !KillE)));
    chk("done",   32'(DoneMC),   32'(m_done));
    chk("result", ResultMC,      m_res);
    chk("zero",   32'(ZeroMC),   32'(m_zero));
  end

  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_st, input logic [31:0] exp_r,
                       input logic exp_z);
    int st = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    StartE = 1'b1; ALUControlE = op; SrcAE = a; SrcBE = b;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (DoneMC) begin
        got = 1'b1;
        chk({nm, "_res"},  ResultMC, exp_r);
        chk({nm, "_zero"}, 32'(ZeroMC), 32'(exp_z));
      end else if (StallMC) begin
        st++;
      end
      if (!got && c == 0) begin
        @(posedge clk); #1;
        SrcAE = $urandom; SrcBE = $urandom;
      end
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_stalls"}, 32'(st), 32'(exp_st));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    StartE = 1'b0; KillE = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int dn;
    rst_n = 1'b0; StartE = 1'b0; KillE = 1'b0;
    ALUControlE = 4'd0; SrcAE = 32'd0; SrcBE = 32'd0;
    repeat (3) @(posedge clk); #1;
    chk("rst_stall",  32'(StallMC), 32'd0);
    chk("rst_done",   32'(DoneMC),  32'd0);
    chk("rst_result", ResultMC,     32'd0);
    chk("rst_zero",   32'(ZeroMC),  32'd1);
    StartE = 1'b1; ALUControlE = OP_MULT; #1;
    chk("rst_idle_stall", 32'(StallMC), 32'd1);
    StartE = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    idle(2);

    do_op("mul7x6",  OP_MULT, 32'd7, 32'd6, 4, 32'd42, 1'b0);
    idle(2);
    do_op("mulmax",  OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'd1, 1'b0);
    idle(2);
    do_op("mul5x0",  OP_MULT, 32'd5, 32'd0, 2, 32'd0, 1'b1);
    idle(2);
    do_op("av_white", OP_AV, 32'h00FFFFFF, 32'd0, 4, 32'd255, 1'b0);
    idle(2);
    do_op("av_b2b",  OP_AV,   32'h006432C8, 32'd0, 4, 32'd82, 1'b0);
    do_op("mul_b2b", OP_MULT, 32'd3, 32'd3, 3, 32'd9, 1'b0);
    idle(2);

    // Kill in the 2nd MUL cycle of 7 x 6.
    @(posedge clk); #1;
    StartE = 1'b1; ALUControlE = OP_MULT; SrcAE = 32'd7; SrcBE = 32'd6;
    @(posedge clk); #1;
    @(posedge clk); #1 KillE = 1'b1;
    @(posedge clk); #1 KillE = 1'b0; StartE = 1'b0;
    chk("kill_stall",  32'(StallMC), 32'd0);
    chk("kill_done",   32'(DoneMC),  32'd0);
    chk("kill_result", ResultMC,     32'd9);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (DoneMC) dn++;
    end
    chk("kill_no_done", 32'(dn), 32'd0);

    // Asynchronous reset in the middle of AVG.
    @(posedge clk); #1;
    StartE = 1'b1; ALUControlE = OP_AV; SrcAE = 32'h006432C8;
    @(posedge clk); #1 StartE = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stall",  32'(StallMC), 32'd0);
    chk("arst_done",   32'(DoneMC),  32'd0);
    chk("arst_result", ResultMC,     32'd0);
    chk("arst_zero",   32'(ZeroMC),  32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(2);
    do_op("av_after_rst", OP_AV, 32'h006432C8, 32'd0, 4, 32'd82, 1'b0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
